// File: rtl/tetris_board_if.sv
// Write port of the tetris playfield.
//   wr_valid/wr_ready : handshake; a write is taken when both are high
//   wr_x, wr_y        : target column / row (row 0 is the top)
//   wr_val            : cell code to store (0 erases)
//   wr_err            : one-cycle pulse after a taken write that was out of range
// master = game logic issuing writes, slave = tetris_board.
interface tetris_board_if #(
    parameter int CW = 4
);
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_x;
    logic [4:0]    wr_y;
    logic [CW-1:0] wr_val;
    logic          wr_err;

    modport master (output wr_valid, wr_x, wr_y, wr_val, input  wr_ready, wr_err);
    modport slave  (input  wr_valid, wr_x, wr_y, wr_val, output wr_ready, wr_err);
endinterface

// File: rtl/tetris_board.sv
// tetris_board: 10x20 playfield store with a bottom-up line-clear engine.
//   Clk, Reset     : clock, asynchronous active-high reset
//   wr             : cell write port (see tetris_board_if)
//   clear_start    : start a line-clear pass (taken only in IDLE)
//   busy           : pass in progress (SCAN/SHIFT/DONE)
//   clear_done     : one-cycle pulse when the pass finishes
//   lines_cleared  : rows removed by the last pass
//   total_lines    : saturating running total of removed rows
//   grid           : registered board, grid[x][y]
// TOTAL_INIT only sets the reset value of total_lines (normally 0).
module tetris_board #(
    parameter int          COLS       = 10,
    parameter int          ROWS       = 20,
    parameter int          CW         = 4,
    parameter logic [15:0] TOTAL_INIT = 16'h0000
) (
    input  logic                               Clk,
    input  logic                               Reset,
    tetris_board_if.slave                      wr,
    input  logic                               clear_start,
    output logic                               busy,
    output logic                               clear_done,
    output logic [4:0]                         lines_cleared,
    output logic [15:0]                        total_lines,
    output logic [COLS-1:0][ROWS-1:0][CW-1:0]  grid
);
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t       state, state_n;
    logic [4:0]   r;
    logic [COLS-1:0] col_occ;
    logic         row_full;
    logic         wr_acc;
    logic         wr_in_range;

    assign wr.wr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign clear_done  = (state == DONE);

    assign wr_acc      = wr.wr_valid && wr.wr_ready;
    assign wr_in_range = (wr.wr_x < 4'(COLS)) && (wr.wr_y < 5'(ROWS));

    // One occupancy bit per column for the row under test.
    for (genvar gx = 0; gx < COLS; gx++) begin : g_col
        assign col_occ[gx] = |grid[gx][r];
    end
    assign row_full = &col_occ;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (clear_start) state_n = SCAN;
            SCAN:    if (row_full) state_n = SHIFT;
                     else if (r == 5'd0) state_n = DONE;
            SHIFT:   state_n = SCAN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            grid          <= '0;
            r             <= '0;
            lines_cleared <= '0;
            total_lines   <= TOTAL_INIT;
            wr.wr_err     <= 1'b0;
        end else begin
            state     <= state_n;
            wr.wr_err <= wr_acc && !wr_in_range;
            case (state)
                IDLE: begin
                    // A write in the same cycle as clear_start lands before the
                    // first SCAN, so the pass sees it.
                    if (wr_acc && wr_in_range)
                        grid[wr.wr_x][wr.wr_y] <= wr.wr_val;
                    if (clear_start) begin
                        r             <= 5'(ROWS - 1);
                        lines_cleared <= '0;
                    end
                end
                SCAN: begin
                    if (!row_full && r != 5'd0)
                        r <= r - 5'd1;
                end
                SHIFT: begin
                    // Collapse everything above r down by one; r stays put so
                    // the row that dropped into it is re-tested.
                    for (int x = 0; x < COLS; x++) begin
                        for (int y = 1; y < ROWS; y++) begin
                            if (5'(y) <= r)
                                grid[x][y] <= grid[x][y-1];
                        end
                        grid[x][0] <= '0;
                    end
                    lines_cleared <= lines_cleared + 5'd1;
                    if (total_lines != 16'hFFFF)
                        total_lines <= total_lines + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_board.sv
// Scoreboard bench for tetris_board. A second instance with a near-saturated
// total_lines reset value shares all stimulus to exercise saturation.
module tb_tetris_board;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CW   = 4;
    localparam int GW   = COLS * ROWS * CW;
    localparam int SAT_INIT = 16'hFFF5;

    typedef logic [COLS-1:0][ROWS-1:0][CW-1:0] grid_t;
    typedef struct { int cyc; int lines; int tot; int sat; grid_t g; } crec_t;
    typedef struct { int cyc; bit inr; grid_t g; } wrec_t;

    logic Clk, Reset, clear_start;
    logic busy, clear_done, busy_b, done_b;
    logic [4:0]  lines, lines_b;
    logic [15:0] total, total_b;
    grid_t grid, grid_b;

    tetris_board_if #(.CW(CW)) wif_a();
    tetris_board_if #(.CW(CW)) wif_b();
    assign wif_b.wr_valid = wif_a.wr_valid;
    assign wif_b.wr_x     = wif_a.wr_x;
    assign wif_b.wr_y     = wif_a.wr_y;
    assign wif_b.wr_val   = wif_a.wr_val;

    tetris_board #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .wr(wif_a.slave), .clear_start(clear_start),
        .busy(busy), .clear_done(clear_done), .lines_cleared(lines),
        .total_lines(total), .grid(grid));

    tetris_board #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .TOTAL_INIT(16'(SAT_INIT))) dut_sat (
        .Clk(Clk), .Reset(Reset), .wr(wif_b.slave), .clear_start(clear_start),
        .busy(busy_b), .clear_done(done_b), .lines_cleared(lines_b),
        .total_lines(total_b), .grid(grid_b));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    crec_t cq[$];
    wrec_t wq[$];
    int mg[COLS][ROWS];
    int m_total;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic grid_t pack_model();
        grid_t g;
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++)
                g[x][y] = mg[x][y][CW-1:0];
        return g;
    endfunction

    function automatic int sat16(input int v);
        return (v > 16'hFFFF) ? 16'hFFFF : v;
    endfunction

    task automatic model_reset();
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++)
                mg[x][y] = 0;
        m_total = 0;
        cq.delete();
        wq.delete();
    endtask

    // Reference pass: drop every full row, keep the rest in order, pad at top.
    task automatic model_clear(input int c0, output int done_c);
        int nb[COLS][ROWS];
        int dst, k;
        bit full;
        crec_t c;
        dst = ROWS - 1;
        k = 0;
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++)
                nb[x][y] = 0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < COLS; x++) if (mg[x][y] == 0) full = 1'b0;
            if (full) k++;
            else begin
                for (int x = 0; x < COLS; x++) nb[x][dst] = mg[x][y];
                dst--;
            end
        end
        mg = nb;
        m_total += k;
        done_c = c0 + 21 + 2 * k;
        c.cyc = done_c; c.lines = k; c.tot = sat16(m_total);
        c.sat = sat16(SAT_INIT + m_total); c.g = pack_model();
        cq.push_back(c);
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic do_write(input int x, input int y, input int v, input bit with_clear,
                            output int acc_c, output int done_c);
        bit ready, ok;
        int c0;
        wrec_t w;
        ok = 1'b0; c0 = 0; done_c = 0;
        wif_a.wr_valid = 1'b1;
        wif_a.wr_x = 4'(x); wif_a.wr_y = 5'(y); wif_a.wr_val = CW'(v);
        clear_start = with_clear;
        for (int i = 0; i < 300; i++) begin
            ready = wif_a.wr_ready;
            c0 = cyc;
            @(posedge Clk); #1;
            clear_start = 1'b0;
            if (ready) begin ok = 1'b1; break; end
        end
        wif_a.wr_valid = 1'b0;
        acc_c = c0;
        if (!ok) begin
            check("write accept timeout", 0, 1);
        end else begin
            w.inr = (x < COLS) && (y < ROWS);
            if (w.inr) mg[x][y] = v;
            w.cyc = c0 + 1; w.g = pack_model();
            wq.push_back(w);
            if (with_clear) model_clear(c0, done_c);
        end
    endtask

    task automatic wr(input int x, input int y, input int v);
        int a, d;
        do_write(x, y, v, 1'b0, a, d);
    endtask

    task automatic do_clear(output int done_c);
        int c0;
        c0 = cyc;
        clear_start = 1'b1;
        @(posedge Clk); #1;
        clear_start = 1'b0;
        model_clear(c0, done_c);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && wif_a.wr_ready) begin ok = 1'b1; break; end
            @(posedge Clk); #1;
        end
        if (!ok) check("idle timeout", 0, 1);
    endtask

    task automatic fill_row(input int y, input int v);
        for (int x = 0; x < COLS; x++) wr(x, y, v);
    endtask

    // Monitor: every cycle compares the event outputs against the queues.
    always @(negedge Clk) begin : mon
        bit ed, ew;
        crec_t c;
        wrec_t w;
        if (!Reset) begin
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                check("clear_done missing", 0, 1);
                void'(cq.pop_front());
            end
            ed = (cq.size() > 0) && (cq[0].cyc == cyc);
            check("clear_done", GW'(clear_done), GW'(ed));
            check("clear_done sat", GW'(done_b), GW'(ed));
            if (ed) begin
                c = cq.pop_front();
                check("lines_cleared", GW'(lines), GW'(c.lines));
                check("lines_cleared sat", GW'(lines_b), GW'(c.lines));
                check("total_lines", GW'(total), GW'(c.tot));
                check("total_lines sat", GW'(total_b), GW'(c.sat));
                check("grid after pass", grid, c.g);
                check("grid after pass sat", grid_b, c.g);
            end
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                check("write record missed", 0, 1);
                void'(wq.pop_front());
            end
            ew = 1'b0;
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                w = wq.pop_front();
                ew = !w.inr;
                check("grid after write", grid, w.g);
            end
            check("wr_err", GW'(wif_a.wr_err), GW'(ew));
            check("wr_err sat", GW'(wif_b.wr_err), GW'(ew));
        end
    end

    initial begin : stim
        int d, a, d2;
        Reset = 1'b1; clear_start = 1'b0;
        wif_a.wr_valid = 1'b0; wif_a.wr_x = '0; wif_a.wr_y = '0; wif_a.wr_val = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        // reset state
        check("rst grid", grid, '0);
        check("rst wr_ready", GW'(wif_a.wr_ready), 1);
        check("rst busy", GW'(busy), 0);
        check("rst total", GW'(total), 0);
        check("rst lines", GW'(lines), 0);
        check("rst total sat", GW'(total_b), GW'(SAT_INIT));

        // range check
        wr(3, 7, 5);
        wr(10, 0, 1);
        wr(4, 20, 9);

        // single row clear plus a write issued while busy
        fill_row(19, 2);
        wr(4, 18, 7);
        do_clear(d);
        do_write(5, 5, 6, 1'b0, a, d2);
        check("busy write accept cycle", GW'(a), GW'(d + 1));
        wait_idle();
        check("single lines", GW'(lines), 1);
        check("single cell 4,19", GW'(grid[4][19]), 7);
        check("single total", GW'(total), 1);

        // reset mid-pass
        fill_row(19, 3);
        do_clear(d);
        repeat (3) begin @(posedge Clk); #1; end
        #1 Reset = 1'b1;
        model_reset();
        #1;
        check("midrst grid", grid, '0);
        check("midrst busy", GW'(busy), 0);
        check("midrst busy sat", GW'(busy_b), 0);
        check("midrst done", GW'(clear_done), 0);
        @(posedge Clk); #1 Reset = 1'b0;
        check("midrst busy after", GW'(busy), 0);
        check("midrst ready sat", GW'(wif_b.wr_ready), 1);
        repeat (70) begin @(posedge Clk); #1; end

        // non-adjacent full rows
        fill_row(19, 1);
        fill_row(17, 6);
        wr(0, 18, 3);
        do_clear(d);
        wait_idle();
        check("nonadj lines", GW'(lines), 2);
        check("nonadj cell 0,19", GW'(grid[0][19]), 3);
        check("nonadj cell 1,19", GW'(grid[1][19]), 0);

        // full board
        for (int y = 0; y < ROWS; y++) fill_row(y, 1);
        do_clear(d);
        wait_idle();
        check("full lines", GW'(lines), 20);
        check("full grid", grid, '0);
        check("full total sat", GW'(total_b), 16'hFFFF);

        // write completing row 19 together with clear_start
        for (int x = 0; x < COLS - 1; x++) wr(x, 19, 2);
        wr(1, 18, 5);
        do_write(9, 19, 4, 1'b1, a, d);
        wait_idle();
        check("wc lines", GW'(lines), 1);
        check("wc cell 1,19", GW'(grid[1][19]), 5);
        check("wc total sat hold", GW'(total_b), 16'hFFFF);

        // randomized boards
        for (int it = 0; it < 8; it++) begin
            for (int y = 0; y < ROWS; y++)
                if ($urandom_range(3) == 0) begin
                    for (int x = 0; x < COLS; x++) wr(x, y, int'($urandom_range(15, 1)));
                end
            for (int j = 0; j < 15; j++)
                wr(int'($urandom_range(11)), int'($urandom_range(21)), int'($urandom_range(15)));
            if ($urandom_range(1) == 1)
                do_write(int'($urandom_range(9)), int'($urandom_range(19)),
                         int'($urandom_range(15)), 1'b1, a, d);
            else
                do_clear(d);
            if (it % 2 == 1) begin
                do_write(int'($urandom_range(9)), int'($urandom_range(19)),
                         int'($urandom_range(15)), 1'b0, a, d2);
                check("rand busy write accept cycle", GW'(a), GW'(d + 1));
            end
            wait_idle();
        end

        repeat (5) begin @(posedge Clk); #1; end
        check("clear queue drained", GW'(cq.size()), 0);
        check("write queue drained", GW'(wq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
